// File: rtl/i2c_master.sv
// i2c_master: single-master I2C register transaction controller with open-drain SDA
module i2c_master #(
  parameter int CLK_DIV = 25
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  input  logic [6:0] dev_id,
  input  logic       rw,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic       iSDA,
  output logic       SCL,
  output logic       oSDA,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [2:0] {IDLE, START, TXBYTE, RXACK, RSTART, RXBYTE, TXNACK, STOP} state_t;
  state_t state, nxt;
  logic [DW-1:0] div;
  logic [1:0] q, bi;
  logic [2:0] bitc;
  logic [6:0] dev_l;
  logic rw_l, nack, tick, bit_end, sample, accept, bi_inc;
  logic [7:0] reg_l, wdata_l, rx_sr, cur_byte;
  assign tick = div == DW'(CLK_DIV - 1);
  assign bit_end = tick && q == 2'd3;
  assign sample = tick && q == 2'd2 && (state == RXACK || state == RXBYTE);
  // a start held through the last STOP cycle chains straight into the next START
  assign accept = start && (state == IDLE || (state == STOP && bit_end));
  assign cur_byte = bi == 2'd0 ? {dev_l, 1'b0} : bi == 2'd1 ? reg_l : rw_l ? {dev_l, 1'b1} : wdata_l;
  assign bi_inc = state == RXACK && bit_end && (nxt == TXBYTE || nxt == RSTART);
  assign busy = state != IDLE;
  // state register plus quarter/bit/byte counters and transaction data
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      div <= '0;
      q <= '0;
      bitc <= '0;
      bi <= '0;
      done <= 1'b0;
      ack_err <= 1'b0;
      rdata <= '0;
      nack <= 1'b0;
      rx_sr <= '0;
      dev_l <= '0;
      rw_l <= 1'b0;
      reg_l <= '0;
      wdata_l <= '0;
    end else begin
      state <= nxt;
      div <= (accept || state == IDLE || tick) ? '0 : div + 1'b1;
      q <= (accept || state == IDLE) ? '0 : q + {1'b0, tick};
      bitc <= accept ? '0 : bitc + {2'b0, bit_end && (state == TXBYTE || state == RXBYTE)};
      bi <= accept ? '0 : bi + {1'b0, bi_inc};
      done <= state == STOP && bit_end;
      if (accept) begin
        dev_l <= dev_id;
        rw_l <= rw;
        reg_l <= reg_addr;
        wdata_l <= wdata;
        ack_err <= 1'b0;
      end else if (sample && state == RXACK && iSDA)
        ack_err <= 1'b1;
      if (sample) begin
        nack <= iSDA;
        rx_sr <= {rx_sr[6:0], iSDA};
      end
      if (state == STOP && bit_end && rw_l && !ack_err)
        rdata <= rx_sr;
    end
  end
  // next state, advanced at the end of each bit period
  always_comb begin
    nxt = state;
    if (accept)
      nxt = START;
    else if (bit_end)
      case (state)
        START, RSTART: nxt = TXBYTE;
        TXBYTE: nxt = bitc == 3'd7 ? RXACK : TXBYTE;
        RXACK: nxt = (nack || (bi == 2'd2 && !rw_l)) ? STOP : bi == 2'd2 ? RXBYTE : (bi == 2'd1 && rw_l) ? RSTART : TXBYTE;
        RXBYTE: nxt = bitc == 3'd7 ? TXNACK : RXBYTE;
        TXNACK: nxt = STOP;
        STOP: nxt = IDLE;
        default: nxt = state;
      endcase
  end
  // bus waveforms per state and quarter; data bits keep SCL high in Q1-Q2
  always_comb begin
    SCL = state == IDLE || (state == START ? q != 2'd3 : state == STOP ? q != 2'd0 : q[0] ^ q[1]);
    oSDA = (state == START || state == RSTART) ? ~q[1] : state == STOP ? q[1] : state == TXBYTE ? cur_byte[~bitc] : 1'b1;
  end
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench with a bus-level responder and decoder
module tb_i2c_master;
  localparam int S = 256, P = 512, A = 768, N = 769;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rw = 1'b0;
  logic [6:0] dev_id = 7'd5;
  logic [7:0] reg_addr = 8'h12, wdata = 8'hA5, rdata, rd_byte = 8'h5C, sr = 8'h00;
  logic scl, osda, busy, done, ack_err, sda_bus;
  logic sdrv = 1'b1, pscl = 1'b1, psda = 1'b1, txm = 1'b0, ack_en = 1'b1;
  int bitn = 0, nb = 0, cmp = 0, fails = 0, n = 0, pulse_at = -1, b2b_at = -1, early = 0;
  int log_q[$], ex[$];
  assign sda_bus = osda & sdrv;
  i2c_master #(.CLK_DIV(4)) dut (.CLK(clk), .Reset(rst), .start(start), .dev_id(dev_id), .rw(rw),
    .reg_addr(reg_addr), .wdata(wdata), .iSDA(sda_bus), .SCL(scl), .oSDA(osda), .busy(busy),
    .done(done), .ack_err(ack_err), .rdata(rdata));
  always #5 clk = ~clk;
  // responder at device level: decodes START/STOP/bytes and ACKs or sends rd_byte
  always @(negedge clk) begin
    if (scl && pscl && psda && !sda_bus) begin
      bitn <= 0; nb <= 0; txm <= 1'b0; sdrv <= 1'b1; log_q.push_back(S);
    end else if (scl && pscl && !psda && sda_bus)
      log_q.push_back(P);
    else if (scl && !pscl) begin
      if (bitn < 8) sr <= {sr[6:0], sda_bus};
      else begin
        log_q.push_back(int'(sr));
        log_q.push_back(A + int'(sda_bus));
        if (nb == 0 && sr[0] && !sda_bus) txm <= 1'b1;
        else if (txm) txm <= 1'b0;
        nb <= nb + 1;
      end
      bitn <= bitn == 8 ? 0 : bitn + 1;
    end else if (!scl && pscl)
      sdrv <= bitn == 8 ? (txm ? 1'b1 : !ack_en) : (txm ? rd_byte[7 - bitn] : 1'b1);
    pscl <= scl;
    psda <= sda_bus;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    cmp++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic check_log(input string tag);
    check({tag, "_len"}, log_q.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      check($sformatf("%s_%0d", tag, i), i < log_q.size() ? log_q[i] : -1, ex[i]);
  endtask
  task automatic accept();
    @(negedge clk);
    log_q.delete();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_at_accept", busy, 1);
  endtask
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (!done && rdata !== 8'h00 && early >= 0) early++;
      if (cnt == pulse_at) begin
        start = 1'b1; dev_id = 7'h22; rw = 1'b1; reg_addr = 8'hEE; wdata = 8'h11;
      end else if (cnt == pulse_at + 1)
        start = 1'b0;
      if (cnt == b2b_at) start = 1'b1;
    end while (!done && cnt < 3000);
    check("done_seen", done, 1);
  endtask
  initial begin
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_scl", scl, 1);
      check("rst_osda", osda, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
    end
    check("rst_ackerr", ack_err, 0);
    check("rst_rdata", rdata, 0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_busy", busy, 0);
    accept();
    wait_done(n);
    check("wr_len", n, 464);
    check("wr_ackerr", ack_err, 0);
    check("wr_busy", busy, 0);
    ex = '{S, 'h0A, A, 'h12, A, 'hA5, A, P};
    check_log("wr_log");
    @(posedge clk);
    @(negedge clk);
    check("done_pulse", done, 0);
    rw = 1'b1; reg_addr = 8'h34;
    accept();
    wait_done(n);
    check("rd_len", n, 624);
    check("rd_rdata", rdata, 8'h5C);
    check("rd_ackerr", ack_err, 0);
    check("rd_early", early, 0);
    early = -1;
    ex = '{S, 'h0A, A, 'h34, A, S, 'h0B, A, 'h5C, N, P};
    check_log("rd_log");
    rw = 1'b0; ack_en = 1'b0;
    accept();
    wait_done(n);
    check("nack_len", n, 176);
    check("nack_ackerr", ack_err, 1);
    ex = '{S, 'h0A, N, P};
    check_log("nack_log");
    @(posedge clk);
    @(negedge clk);
    check("nack_held", ack_err, 1);
    ack_en = 1'b1; reg_addr = 8'h12; wdata = 8'h3C; pulse_at = 100;
    accept();
    check("ackerr_clear", ack_err, 0);
    wait_done(n);
    pulse_at = -1;
    check("busy_len", n, 464);
    ex = '{S, 'h0A, A, 'h12, A, 'h3C, A, P};
    check_log("busy_log");
    dev_id = 7'd5; rw = 1'b0; reg_addr = 8'h12; wdata = 8'h3C; b2b_at = 463;
    accept();
    wait_done(n);
    start = 1'b0;
    b2b_at = -1;
    check("b2b_len1", n, 464);
    check("b2b_busy", busy, 1);
    wait_done(n);
    check("b2b_len2", n, 464);
    ex = '{S, 'h0A, A, 'h12, A, 'h3C, A, P, S, 'h0A, A, 'h12, A, 'h3C, A, P};
    check_log("b2b_log");
    accept();
    repeat (216) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_scl", scl, 1);
    check("mid_osda", osda, 1);
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    reg_addr = 8'h56; wdata = 8'h99;
    repeat (20) @(posedge clk);
    accept();
    wait_done(n);
    check("post_len", n, 464);
    check("post_ackerr", ack_err, 0);
    check("post_rdata", rdata, 8'h00);
    ex = '{S, 'h0A, A, 'h56, A, 'h99, A, P};
    check_log("post_log");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end
endmodule
